// File: rtl/c_fifo_tracked.sv
// Single-clock circular FIFO whose storage pointers and occupancy counter update
// together, so the status/credit view can never drift from the stored contents.
module c_fifo_tracked #(
  parameter int depth         = 8,
  parameter int width         = 16,
  parameter bit enable_bypass = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_active,
  input  logic                       pop_active,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           push_data,
  output logic [width-1:0]           pop_data,
  output logic                       almost_empty,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] free,
  output logic [1:0]                 errors
);

  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
  localparam int cnt_w = $clog2(depth + 1);
  localparam logic [ptr_w-1:0] ptr_last  = ptr_w'(depth - 1);
  localparam logic [cnt_w-1:0] cnt_depth = cnt_w'(depth);

  logic [ptr_w-1:0] head_reg, head_next;
  logic [ptr_w-1:0] tail_reg, tail_next;
  logic [cnt_w-1:0] occ_reg, occ_next;
  logic [cnt_w-1:0] free_reg;
  logic             empty_reg, almost_empty_reg, almost_full_reg, full_reg;

  logic             push_eff, pop_eff;
  logic             bypass, push_ok, pop_ok;
  logic [width-1:0] entry_q [depth];

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_last) ? '0 : p + ptr_w'(1);
  endfunction

  assign push_eff = push & push_active;
  assign pop_eff  = pop & pop_active;

  // A push+pop into an empty FIFO forwards the word and leaves the state untouched.
  assign bypass  = enable_bypass & push_eff & pop_eff & empty_reg;
  assign pop_ok  = pop_eff & ~empty_reg;
  assign push_ok = push_eff & (~full_reg | pop_eff) & ~bypass;

  always_comb begin
    head_next = pop_ok  ? ptr_inc(head_reg) : head_reg;
    tail_next = push_ok ? ptr_inc(tail_reg) : tail_reg;
    occ_next  = occ_reg;
    case ({push_ok, pop_ok})
      2'b10:   occ_next = occ_reg + cnt_w'(1);
      2'b01:   occ_next = occ_reg - cnt_w'(1);
      default: occ_next = occ_reg;
    endcase
  end

  // Status flags are registered from the next occupancy, so outputs never see push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      occ_reg          <= '0;
      free_reg         <= cnt_depth;
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b0;
      almost_full_reg  <= 1'b0;
      full_reg         <= 1'b0;
    end else begin
      head_reg         <= head_next;
      tail_reg         <= tail_next;
      occ_reg          <= occ_next;
      free_reg         <= cnt_depth - occ_next;
      empty_reg        <= (occ_next == '0);
      almost_empty_reg <= (occ_next == cnt_w'(1));
      almost_full_reg  <= (occ_next == cnt_w'(depth - 1));
      full_reg         <= (occ_next == cnt_depth);
    end
  end

  // Storage entries carry no reset; each one loads only when the tail points at it.
  for (genvar gi = 0; gi < depth; gi++) begin : g_entry
    logic [width-1:0] data_reg;

    always_ff @(posedge clk) begin
      if (push_ok && (tail_reg == ptr_w'(gi))) begin
        data_reg <= push_data;
      end
    end

    assign entry_q[gi] = data_reg;
  end

  assign pop_data = (enable_bypass && empty_reg) ? push_data : entry_q[head_reg];

  assign errors[0] = pop_eff & empty_reg & ~(enable_bypass & push_eff);
  assign errors[1] = push_eff & full_reg & ~pop_eff;

  assign empty        = empty_reg;
  assign almost_empty = almost_empty_reg;
  assign almost_full  = almost_full_reg;
  assign full         = full_reg;
  assign free         = free_reg;

endmodule

// File: tb/tb_c_fifo_tracked.sv
// Self-checking bench for c_fifo_tracked: directed scenarios plus randomized traffic
// compared against a queue model of the FIFO.
module tb_c_fifo_tracked;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             push_active, pop_active;
  logic             push, pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] pop_data;
  logic             almost_empty, empty, almost_full, full;
  logic [3:0]       free;
  logic [1:0]       errors;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q [$];

  c_fifo_tracked #(.depth(DEPTH), .width(WIDTH), .enable_bypass(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .push_active  (push_active),
    .pop_active   (pop_active),
    .push         (push),
    .pop          (pop),
    .push_data    (push_data),
    .pop_data     (pop_data),
    .almost_empty (almost_empty),
    .empty        (empty),
    .almost_full  (almost_full),
    .full         (full),
    .free         (free),
    .errors       (errors)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Apply inputs mid-cycle, then let combinational outputs settle.
  task automatic drive(input logic p, input logic o, input logic [WIDTH-1:0] d);
    @(negedge clk);
    push = p;
    pop = o;
    push_data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: bypass on empty, pop-then-push, drop pushes into a still-full FIFO.
  task automatic model_step(input logic p, input logic o, input logic [WIDTH-1:0] d);
    if (p && o && q.size() == 0) return;
    if (o && q.size() > 0) void'(q.pop_front());
    if (p && q.size() < DEPTH) q.push_back(d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push_active = 1'b1;
    pop_active = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    push_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({empty, almost_empty, almost_full, full} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: actual=%b required=1000", {empty, almost_empty, almost_full, full});
    end
    total++;
    if (free !== 4'd8) begin
      bad++;
      $display("FAIL reset_free: actual=%0d required=8", free);
    end
    total++;
    if (errors !== 2'b00) begin
      bad++;
      $display("FAIL reset_errors: actual=%b required=00", errors);
    end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, WIDTH'(i));
      tick();
      model_step(1'b1, 1'b0, WIDTH'(i));
      total++;
      if ({almost_empty, almost_full, full, free} !== {i == 0, i == DEPTH - 2, i == DEPTH - 1, 4'(DEPTH - 1 - i)}) begin
        bad++;
        $display("FAIL fill_status[%0d]: actual ae=%b af=%b f=%b free=%0d required ae=%b af=%b f=%b free=%0d",
                 i, almost_empty, almost_full, full, free, i == 0, i == DEPTH - 2, i == DEPTH - 1, DEPTH - 1 - i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, '0);
      total++;
      if (pop_data !== WIDTH'(i)) begin
        bad++;
        $display("FAIL drain_data[%0d]: actual=%h required=%h", i, pop_data, WIDTH'(i));
      end
      tick();
      model_step(1'b0, 1'b1, '0);
    end
    drive(1'b0, 1'b0, '0);
    total++;
    if (empty !== 1'b1 || free !== 4'd8) begin
      bad++;
      $display("FAIL drain_empty: actual empty=%b free=%0d required empty=1 free=8", empty, free);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 16'h00AB);
    total++;
    if (pop_data !== 16'h00AB || errors !== 2'b00) begin
      bad++;
      $display("FAIL bypass_data: actual data=%h err=%b required data=00ab err=00", pop_data, errors);
    end
    tick();
    model_step(1'b1, 1'b1, 16'h00AB);
    drive(1'b0, 1'b0, '0);
    total++;
    if (empty !== 1'b1 || free !== 4'd8) begin
      bad++;
      $display("FAIL bypass_state: actual empty=%b free=%0d required empty=1 free=8", empty, free);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, WIDTH'(i));
      tick();
      model_step(1'b1, 1'b0, WIDTH'(i));
    end
    drive(1'b1, 1'b1, 16'h0008);
    total++;
    if (pop_data !== 16'h0000 || errors !== 2'b00) begin
      bad++;
      $display("FAIL fullpp_data: actual data=%h err=%b required data=0000 err=00", pop_data, errors);
    end
    tick();
    model_step(1'b1, 1'b1, 16'h0008);
    drive(1'b0, 1'b0, '0);
    total++;
    if (full !== 1'b1 || free !== 4'd0) begin
      bad++;
      $display("FAIL fullpp_full: actual full=%b free=%0d required full=1 free=0", full, free);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 1'b1, '0);
      total++;
      if (pop_data !== WIDTH'(i)) begin
        bad++;
        $display("FAIL fullpp_drain[%0d]: actual=%h required=%h", i, pop_data, WIDTH'(i));
      end
      tick();
      model_step(1'b0, 1'b1, '0);
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, 16'h1234);
    total++;
    if (errors !== 2'b01) begin
      bad++;
      $display("FAIL underflow_err: actual=%b required=01", errors);
    end
    tick();
    model_step(1'b0, 1'b1, 16'h1234);
    drive(1'b0, 1'b0, '0);
    total++;
    if (empty !== 1'b1 || free !== 4'd8 || errors !== 2'b00) begin
      bad++;
      $display("FAIL underflow_state: actual empty=%b free=%0d err=%b required empty=1 free=8 err=00",
               empty, free, errors);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 16'h0100 + WIDTH'(i));
      tick();
      model_step(1'b1, 1'b0, 16'h0100 + WIDTH'(i));
    end
    drive(1'b1, 1'b0, 16'hDEAD);
    total++;
    if (errors !== 2'b10) begin
      bad++;
      $display("FAIL overflow_err: actual=%b required=10", errors);
    end
    tick();
    model_step(1'b1, 1'b0, 16'hDEAD);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, '0);
      total++;
      if (pop_data !== 16'h0100 + WIDTH'(i)) begin
        bad++;
        $display("FAIL overflow_contents[%0d]: actual=%h required=%h", i, pop_data, 16'h0100 + WIDTH'(i));
      end
      tick();
      model_step(1'b0, 1'b1, '0);
    end
    drive(1'b0, 1'b0, '0);
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL overflow_final_empty: actual=%b required=1", empty);
    end
  endtask

  task automatic test_active_gating();
    push_active = 1'b0;
    drive(1'b1, 1'b0, 16'h5555);
    tick();
    push_active = 1'b1;
    drive(1'b0, 1'b0, '0);
    total++;
    if (empty !== 1'b1 || free !== 4'd8) begin
      bad++;
      $display("FAIL gated_push: actual empty=%b free=%0d required empty=1 free=8", empty, free);
    end
    drive(1'b1, 1'b0, 16'h7777);
    tick();
    model_step(1'b1, 1'b0, 16'h7777);
    pop_active = 1'b0;
    drive(1'b0, 1'b1, '0);
    tick();
    pop_active = 1'b1;
    drive(1'b0, 1'b0, '0);
    total++;
    if (almost_empty !== 1'b1 || pop_data !== 16'h7777) begin
      bad++;
      $display("FAIL gated_pop: actual ae=%b data=%h required ae=1 data=7777", almost_empty, pop_data);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, WIDTH'($urandom));
      tick();
    end
    @(negedge clk);
    push = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (empty !== 1'b1 || free !== 4'd8 || almost_empty !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: actual empty=%b ae=%b free=%0d required empty=1 ae=0 free=8",
               empty, almost_empty, free);
    end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_random();
    logic             p, o;
    logic [WIDTH-1:0] d, exp_data;
    int               n, sz;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      p = ($urandom % 2 == 1) && (q.size() < DEPTH);
      o = ($urandom % 2 == 1) && (q.size() > 0 || p);
      d = WIDTH'($urandom);
      exp_data = (q.size() == 0) ? d : q[0];
      drive(p, o, d);
      if (o) begin
        total++;
        if ($isunknown(pop_data) || pop_data !== exp_data) begin
          bad++;
          $display("FAIL rand_data[%0d]: actual=%h required=%h", cyc, pop_data, exp_data);
        end
      end
      tick();
      model_step(p, o, d);
      sz = q.size();
      total++;
      if ({empty, almost_empty, almost_full, full, free} !== {sz == 0, sz == 1, sz == DEPTH - 1, sz == DEPTH, 4'(DEPTH - sz)}) begin
        bad++;
        $display("FAIL rand_status[%0d]: actual e=%b ae=%b af=%b f=%b free=%0d required occupancy=%0d",
                 cyc, empty, almost_empty, almost_full, full, free, sz);
      end
    end
    n = 0;
    while (q.size() > 0 && n < 2 * DEPTH) begin
      exp_data = q[0];
      drive(1'b0, 1'b1, '0);
      total++;
      if (pop_data !== exp_data) begin
        bad++;
        $display("FAIL rand_drain[%0d]: actual=%h required=%h", n, pop_data, exp_data);
      end
      tick();
      model_step(1'b0, 1'b1, '0);
      n++;
    end
    drive(1'b0, 1'b0, '0);
    total++;
    if (empty !== 1'b1 || q.size() != 0) begin
      bad++;
      $display("FAIL rand_final: actual empty=%b model_left=%0d required empty=1 model_left=0", empty, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_bypass();
    test_full_push_pop();
    test_underflow();
    test_overflow();
    test_active_gating();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
